// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
//
// W-bit add/subtract (W = 4*NIB) built around one 4-bit ripple-carry stage.
// The stage is reused once per nibble, least significant nibble first, so a
// result takes NIB cycles. Requests and results use valid/ready handshakes.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand request valid
//   in_ready   block can accept a request (IDLE only)
//   a, b       W-bit operands (unsigned or two's complement)
//   sub        0: a+b, 1: a-b
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts the result
//   sum        W-bit result, modulo 2^W
//   c_out      carry out of the MSB; on subtract 1 means no borrow
//   ovf        signed two's-complement overflow
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for in_valid; in_ready=1
// RUN   | one nibble per cycle through the 4-bit stage
// DONE  | result held on sum/c_out/ovf until out_ready; out_valid=1

module nibble_serial_adder_ctrl #(
  parameter int NIB = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4*NIB-1:0] a,
  input  logic [4*NIB-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4*NIB-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int W  = 4 * NIB;
  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            c_out_q, c_out_d;
  logic            ovf_q, ovf_d;

  // Shared 4-bit ripple-carry stage
  logic [3:0]      st_a, st_b, st_s;
  logic [4:0]      st_c;
  logic [IW+1:0]   nib_base;

  assign nib_base = {idx_q, 2'b00};
  assign st_a     = a_q[nib_base +: 4];
  assign st_b     = b_q[nib_base +: 4];

  always_comb begin
    st_c    = '0;
    st_s    = '0;
    st_c[0] = carry_q;
    for (int i = 0; i < 4; i++) begin
      st_s[i]   = st_a[i] ^ st_b[i] ^ st_c[i];
      st_c[i+1] = (st_a[i] & st_b[i]) | (st_c[i] & (st_a[i] ^ st_b[i]));
    end
  end

  // Subtraction is a + ~b + 1: the inverted B is stored and the "+1" enters
  // as the initial carry-in, so the carry register also carries the sub flag.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        sum_d[nib_base +: 4] = st_s;
        carry_d              = st_c[4];
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          c_out_d = st_c[4];
          // Operands of equal sign producing a result of the other sign.
          ovf_d   = ~(a_q[W-1] ^ b_q[W-1]) & (st_s[3] ^ a_q[W-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
module tb_nibble_serial_adder_ctrl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  nibble_serial_adder_ctrl #(.NIB(NIB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: plain W-bit integer arithmetic.
  task automatic ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rs,
                           output logic [W-1:0] rsum, output logic rc, output logic rv);
    int sa, sb, r;
    logic [W:0] wide;
    sa = int'($signed(ra));
    sb = int'($signed(rb));
    if (rs) begin
      rsum = ra - rb;
      rc   = (ra >= rb);
      r    = sa - sb;
    end else begin
      wide = {1'b0, ra} + {1'b0, rb};
      rsum = wide[W-1:0];
      rc   = wide[W];
      r    = sa + sb;
    end
    rv = (r > 32767) || (r < -32768);
  endtask

  // One request with a given number of backpressure cycles in DONE.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                        input int hold, input string tag);
    logic [W-1:0] es;
    logic ec, ev;
    int lat;
    logic [W-1:0] s0;
    logic c0, v0;
    ref_model(ta, tb_v, ts, es, ec, ev);
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb_v;
    sub       = ts;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    sub      = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat < NIB) begin
        a   = W'($urandom);
        b   = W'($urandom);
        sub = 1'($urandom);
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(NIB));
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_c_out"}, 32'(c_out), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf), 32'(ev));
    s0 = sum; c0 = c_out; v0 = ovf;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      a        = W'($urandom);
      b        = W'($urandom);
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_hold_res"}, {15'd0, c_out, sum}, {15'd0, c0, s0});
      chk({tag, "_hold_ovf"}, 32'(ovf), 32'(v0));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_ret_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_ret_ready"}, 32'(in_ready), 32'd1);
  endtask

  logic [W-1:0] qa[$], qb[$];
  logic         qs[$];

  task automatic back_to_back();
    int pushed, got, last;
    logic [W-1:0] es, ta, tbv;
    logic ec, ev, ts;
    pushed = 0; got = 0; last = 0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int c = 0; c < 120 && got < 8; c++) begin
      if (out_valid) begin
        ta = qa.pop_front(); tbv = qb.pop_front(); ts = qs.pop_front();
        ref_model(ta, tbv, ts, es, ec, ev);
        chk("b2b_sum", 32'(sum), 32'(es));
        chk("b2b_flags", {30'd0, c_out, ovf}, {30'd0, ec, ev});
        if (got > 0) chk("b2b_period", 32'(cyc - last), 32'(NIB + 2));
        last = cyc;
        got++;
      end
      if (in_ready) begin
        if (pushed < 8) begin
          ta = W'($urandom); tbv = W'($urandom); ts = 1'($urandom);
          in_valid = 1'b1; a = ta; b = tbv; sub = ts;
          qa.push_back(ta); qb.push_back(tbv); qs.push_back(ts);
          pushed++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    chk("b2b_count", 32'(got), 32'd8);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", {15'd0, c_out, sum}, 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h4321, 1'b0, 0, "d_5555");
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, "d_ripple");
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, "d_ovf_add");
    run_op(16'h0005, 16'h0007, 1'b1, 0, "d_borrow");
    run_op(16'h8000, 16'h0001, 1'b1, 0, "d_ovf_sub");
    run_op(16'h0000, 16'h0000, 1'b1, 0, "d_zero_sub");
    run_op(16'hA5C3, 16'h1F0E, 1'b0, 10, "d_backpr");

    for (int i = 0; i < 16; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rnd");

    // Abort mid-RUN at idx=2.
    @(negedge clk);
    in_valid = 1'b1; a = 16'h1234; b = 16'h4321; sub = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_flags", {30'd0, c_out, ovf}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (NIB + 4) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    run_op(16'h8001, 16'h7FFF, 1'b1, 1, "post_abort");

    back_to_back();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got stalled bench expected completion");
    $fatal(1);
  end

endmodule
